// File: rtl/prince_pkg.sv
// Shared PRINCE definitions for the masked decryption datapath.
package prince_pkg;

  localparam int NIBBLES = 16;

  // Unmasked inverse S-box table. It is a reference for checking only; the
  // masked datapath derives everything from share-wise component logic.
  localparam logic [3:0] INV_S [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

endpackage

// File: rtl/prince_inv_sbox_layer_d1_if.sv
// Request/response bundle of the masked inverse S-box layer.
interface prince_inv_sbox_layer_d1_if #(parameter int NIB_PER_BEAT = 4);
  logic                      start;
  logic [63:0]               in_s0;
  logic [63:0]               in_s1;
  logic [4*NIB_PER_BEAT-1:0] rnd;
  logic                      busy;
  logic                      done;
  logic [63:0]               out_s0;
  logic [63:0]               out_s1;

  modport master (output start, in_s0, in_s1, rnd,
                  input  busy, done, out_s0, out_s1);
  modport slave  (input  start, in_s0, in_s1, rnd,
                  output busy, done, out_s0, out_s1);
endinterface

// File: rtl/prince_inv_sbox_d1.sv
// Single-nibble, two-share masked PRINCE inverse S-box.
// The algebraic normal form is expanded over all 16 share-index tuples; each
// tuple component only touches one share of every input bit, so no component
// ever sees both shares of a variable. Components are registered (glitch
// barrier) and only then compressed back into two output shares.
module prince_inv_sbox_d1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] r,
  output logic [3:0] b0,
  output logic [3:0] b1
);

  // ANF coefficients per output bit: bit u set means monomial prod_{j in u} x_j.
  //   y0 = 1^x0x1^x1x2^x3^x0x1x3^x2x3^x0x2x3
  //   y1 = 1^x0x2^x1x2^x0x1x2^x1x3^x2x3
  //   y2 = x0^x0x1^x2^x0x2^x1x2^x0x1x2^x1x3^x0x1x3
  //   y3 = 1^x0^x1^x0x1^x0x2^x1x2^x0x1x2^x2x3^x0x2x3^x1x2x3
  localparam logic [3:0][15:0] ANF = {16'h70EF, 16'h0CFA, 16'h14E1, 16'h3949};

  // Component for share tuple s: each monomial term is placed in the unique
  // tuple whose unused variables select share 0, so every term appears once.
  function automatic logic [3:0] comp_fn(input logic [3:0] s,
                                         input logic [3:0] x0,
                                         input logic [3:0] x1);
    logic [3:0] y;
    logic [3:0] uu;
    logic       t;
    y = '0;
    for (int b = 0; b < 4; b++) begin
      for (int u = 0; u < 16; u++) begin
        uu = 4'(u);
        t  = ANF[2'(b)][uu] & ((s & ~uu) == 4'h0);
        for (int j = 0; j < 4; j++)
          if (uu[2'(j)]) t = t & (s[2'(j)] ? x1[2'(j)] : x0[2'(j)]);
        y[2'(b)] = y[2'(b)] ^ t;
      end
    end
    return y;
  endfunction

  logic [15:0][3:0] comp, comp_q;

  // Share-wise components; one component per output-share group gets the same
  // fresh mask so it cancels on recombination.
  always_comb begin
    comp = '0;
    for (int s = 0; s < 16; s++)
      comp[4'(s)] = comp_fn(4'(s), a0, a1) ^ ((s == 0 || s == 15) ? r : 4'h0);
  end

  // Glitch barrier register.
  always_ff @(posedge clk) begin
    if (rst) comp_q <= '0;
    else     comp_q <= comp;
  end

  // Compress: tuples using share 0 of x3 form out share 0, the rest share 1.
  always_comb begin
    b0 = '0;
    b1 = '0;
    for (int s = 0; s < 16; s++) begin
      if (s < 8) b0 = b0 ^ comp_q[4'(s)];
      else       b1 = b1 ^ comp_q[4'(s)];
    end
  end

endmodule

// File: rtl/prince_inv_sbox_layer_d1.sv
// Masked inverse S-box layer: 16 nibbles, NIB_PER_BEAT per issue cycle.
module prince_inv_sbox_layer_d1
  import prince_pkg::*;
#(
  parameter int NIB_PER_BEAT = 4
) (
  input logic                        clk,
  input logic                        rst,
  prince_inv_sbox_layer_d1_if.slave  bus
);

  localparam int BEATS = NIBBLES / NIB_PER_BEAT;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [NIB_PER_BEAT-1:0][3:0] grp_t;

  state_t                 state, state_nxt;
  logic [KW-1:0]          k;
  logic [KW-1:0]          wr_beat;
  logic                   wr_vld;
  logic [BEATS-1:0][NIB_PER_BEAT*4-1:0] ld_s0, ld_s1, out_s0_q, out_s1_q;
  grp_t                   cur_s0, cur_s1, sb_s0, sb_s1;

  assign cur_s0 = ld_s0[k];
  assign cur_s1 = ld_s1[k];

  for (genvar j = 0; j < NIB_PER_BEAT; j++) begin : g_sb
    prince_inv_sbox_d1 u_sb (
      .clk (clk),
      .rst (rst),
      .a0  (cur_s0[j]),
      .a1  (cur_s1[j]),
      .r   (bus.rnd[4*j +: 4]),
      .b0  (sb_s0[j]),
      .b1  (sb_s1[j])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only counts in IDLE; DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (k == KW'(BEATS - 1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load, beat counter and delayed nibble-group write into the output shares.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_s0    <= '0;
      ld_s1    <= '0;
      k        <= '0;
      wr_vld   <= 1'b0;
      wr_beat  <= '0;
      out_s0_q <= '0;
      out_s1_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        ld_s0 <= bus.in_s0;
        ld_s1 <= bus.in_s1;
        k     <= '0;
      end
      if (state == ISSUE) k <= k + 1'b1;
      wr_vld  <= (state == ISSUE);
      wr_beat <= k;
      if (wr_vld) begin
        out_s0_q[wr_beat] <= sb_s0;
        out_s1_q[wr_beat] <= sb_s1;
      end
    end
  end

  assign bus.busy   = (state == ISSUE) || (state == FLUSH);
  assign bus.done   = (state == DONE);
  assign bus.out_s0 = out_s0_q;
  assign bus.out_s1 = out_s1_q;

endmodule

// File: tb/tb_prince_inv_sbox_layer_d1.sv
// Scoreboard bench for the masked inverse S-box layer.
module tb_prince_inv_sbox_layer_d1;

  logic clk = 1'b0;
  logic rst;

  prince_inv_sbox_layer_d1_if #(.NIB_PER_BEAT(4)) bus ();

  prince_inv_sbox_layer_d1 #(.NIB_PER_BEAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] REF [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  typedef struct {
    logic [63:0] exp;
    bit          s1_nz;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   chks = 0;

  function automatic logic [63:0] model(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = REF[x[4*i +: 4]];
    return y;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_done at %0t", $time);
        end else begin
          e = sbq.pop_front();
          check("recombined", bus.out_s0 ^ bus.out_s1, e.exp);
          if (e.s1_nz) begin
            chks++;
            if (bus.out_s1 == 64'h0) begin
              errs++;
              $display("FAIL out_s1_nonzero: got %h expected nonzero", bus.out_s1);
            end
          end
        end
      end
    end
  end

  // Issue one operation from an IDLE cycle; returns in the cycle after DONE.
  task automatic run_op(input logic [63:0] s0, input logic [63:0] s1,
                        input bit nz, input bit zero_rnd);
    bit ok;
    bus.start = 1'b1;
    bus.in_s0 = s0;
    bus.in_s1 = s1;
    sbq.push_back('{exp: model(s0 ^ s1), s1_nz: nz});
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (zero_rnd)         bus.rnd = '0;
      else if (nz && b == 0) bus.rnd = 16'($urandom_range(1, 65535));
      else                  bus.rnd = 16'($urandom);
      tick();
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.done === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      chks++;
      errs++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
    tick();
  endtask

  initial begin : stim
    logic [63:0] m, x, y, z;
    logic [7:0]  p;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in_s0 = '0;
    bus.in_s1 = '0;
    bus.rnd   = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_out_s0", bus.out_s0, 64'h0);
    check("reset_out_s1", bus.out_s1, 64'h0);

    // All-zero shares with cycle-exact busy/done profile.
    bus.start = 1'b1;
    sbq.push_back('{exp: 64'hBBBBBBBBBBBBBBBB, s1_nz: 1'b0});
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("busy_profile", {63'b0, bus.busy}, {63'b0, (c <= 5)});
      check("done_profile", {63'b0, bus.done}, {63'b0, (c == 6)});
      if (c < 6) tick();
    end
    tick();

    // Unmasked counting pattern, fresh nonzero randomness.
    run_op(64'h0123456789ABCDEF, 64'h0, 1'b1, 1'b0);

    // Random masks on the same value.
    for (int i = 0; i < 1000; i++) begin
      m = {$urandom, $urandom};
      run_op(64'h0123456789ABCDEF ^ m, m, 1'b0, 1'b0);
    end

    // Starts during ISSUE and DONE are ignored; held start after DONE launches.
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    z = {$urandom, $urandom};
    bus.start = 1'b1;
    bus.in_s0 = x;
    bus.in_s1 = 64'h0;
    sbq.push_back('{exp: model(x), s1_nz: 1'b0});
    for (int c = 1; c <= 13; c++) begin
      tick();
      bus.rnd   = 16'($urandom);
      bus.start = (c == 2 || c == 6 || c == 7);
      if (c == 2) bus.in_s0 = y;
      if (c == 6) begin
        bus.in_s0 = z;
        sbq.push_back('{exp: model(z), s1_nz: 1'b0});
      end
      check("repulse_done", {63'b0, bus.done}, {63'b0, (c == 6 || c == 13)});
      if (c == 8) check("hold_after_start", bus.out_s0 ^ bus.out_s1, model(x));
    end
    tick();

    // Reset mid-operation aborts without a done pulse.
    bus.start = 1'b1;
    bus.in_s0 = {$urandom, $urandom};
    bus.in_s1 = {$urandom, $urandom};
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_done", {63'b0, bus.done}, 64'd0);
    check("abort_out_s0", bus.out_s0, 64'h0);
    check("abort_out_s1", bus.out_s1, 64'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("abort_no_done", {63'b0, bus.done}, 64'd0);
    end

    // Every share pair on nibble 0.
    for (int i = 0; i < 256; i++) begin
      p = 8'(i);
      run_op({60'h0, p[3:0]}, {60'h0, p[7:4]}, 1'b0, 1'b0);
    end

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/prince_inv_sbox_layer_d1.md
# prince_inv_sbox_layer_d1

First-order (two-share) masked inverse S-box layer for the PRINCE decryption datapath. It applies the PRINCE inverse S-box to all 16 nibbles of a shared 64-bit state, four nibbles per cycle. It is the inverse-direction counterpart of the masked forward S-box layer in the encryption core. The block sits between the inverse linear layer and the round-key addition in the round-based decryption core, and it is also usable standalone as a PROLEAD evaluation target.

## Interface
Parameters:
- NIB_PER_BEAT, 4, nibbles processed per issue cycle; must divide 16.
- BEATS, 16/NIB_PER_BEAT (= 4), derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- in_s0  in  64  state share 0; sampled with start.
- in_s1  in  64  state share 1; sampled with start.
- rnd  in  4*NIB_PER_BEAT  fresh randomness; sampled every issue cycle.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when out shares are complete.
- out_s0  out  64  result share 0; held until next accepted start.
- out_s1  out  64  result share 1; held until next accepted start.

## Operation
- Nibble i occupies bits [4i+3:4i]. Nibble position is preserved from input to output.
- Functional rule, per nibble: out_s0 ^ out_s1 = INV_S(in_s0 ^ in_s1).
- INV_S, indexed 0..F, is B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1.
- Shares are never recombined inside the block. Each masked nibble function is split into per-share component functions, followed by one register stage that acts as a glitch barrier. Each output nibble share is refreshed with 4 bits of rnd.
- rnd bits [4j+3:4j] refresh nibble j of the current beat.
- FSM states:
  - IDLE: waits for start. On start, latch in_s0/in_s1 into the load registers, clear beat counter, go to ISSUE.
  - ISSUE: beat counter k = 0..BEATS-1. Feed nibbles NIB_PER_BEAT*k .. NIB_PER_BEAT*k+NIB_PER_BEAT-1 of both shares into the masked S-box stage. After k = BEATS-1, go to FLUSH.
  - FLUSH: the last beat's registered results are written into the output registers. Go to DONE.
  - DONE: done=1 for this single cycle. Go to IDLE.
- Output registers are written nibble-group-wise, one cycle after the corresponding beat is issued.
- out_s0/out_s1 change only during an operation. They are stable from DONE until the cycle after the next accepted start.
- start while not in IDLE: ignored. No queueing and no effect.
- start asserted on the same cycle as DONE: ignored, because DONE is not IDLE. It is accepted on the following cycle if it is still high.
- Reset (including mid-operation):
  - FSM goes to IDLE, busy=0, done=0.
  - out_s0, out_s1, the load registers and the pipeline registers all become 0.
  - No done pulse is issued for an aborted operation.

## Timing
- start sampled high in IDLE at cycle T.
- Beat k is issued in cycle T+1+k and its result is registered at the end of that cycle.
- The result is written to the output register at the end of cycle T+2+k.
- Cycles T+1..T+4 are ISSUE, T+5 is FLUSH, T+6 is DONE.
- busy=1 in cycles T+1..T+5. busy=0 in T+6.
- done=1 in T+6 only. out shares are complete and valid from T+6.
- Latency from start to done is 6 cycles. Minimum start-to-start spacing is 7 cycles.
- rnd must be fresh in each ISSUE cycle. rnd is don't-care in all other cycles.

## Structure
- Shared package prince_pkg holds:
  - the INV_S constant (verification reference only, never synthesised into the masked path);
  - NIBBLES = 16;
  - the FSM state enum (IDLE, ISSUE, FLUSH, DONE).
- One sub-module, prince_inv_sbox_d1:
  - a single-nibble two-share masked inverse S-box;
  - per-share component logic, rnd refresh, and one internal register stage;
  - it contains no control logic.
- The top instantiates NIB_PER_BEAT copies of it, plus the FSM, beat counter, input muxing and output registers.

## Test plan
- Reset, then in_s0=0, in_s1=0, rnd=0, start:
  - busy T+1..T+5, done only at T+6;
  - out_s0^out_s1 = 0xBBBBBBBBBBBBBBBB.
- in_s0=0x0123456789ABCDEF, in_s1=0, random rnd:
  - out_s0^out_s1 = 0xB732FD89A6405EC1;
  - out_s1 is nonzero for nonzero rnd.
- in_s0=0x0123456789ABCDEF^M, in_s1=M for 1000 random M and rnd:
  - recombined result always 0xB732FD89A6405EC1.
- Re-pulse start during T+2 and again at T+6:
  - both ignored; exactly one done;
  - a start at T+7 launches a new operation with done at T+13.
- Assert rst at T+3:
  - next cycle IDLE, busy=0, outputs 0;
  - no done within 10 cycles without a new start.
- Exhaustive single-nibble check:
  - all 256 (share0, share1) pairs on nibble 0 with other nibbles 0;
  - each recombined result matches INV_S(share0^share1).
